// File: rtl/dedup_packer.sv
// Packs the kept lanes of deduplicated beats into dense output beats,
// preserving frame boundaries and counting unique and duplicate lanes.
module dedup_packer #(
    parameter type         data_t       = logic [7:0],
    parameter int unsigned NUM_ELEMENTS = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_ELEMENTS-1:0]                      in_mask_duplicates,
    input  logic [NUM_ELEMENTS*$clog2(NUM_ELEMENTS)-1:0] in_mask_origins,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  data_t [NUM_ELEMENTS-1:0]                     in_data,
    input  logic [NUM_ELEMENTS-1:0]                      in_keep,
    input  logic                                         in_last,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output data_t [NUM_ELEMENTS-1:0]                     out_data,
    output logic [NUM_ELEMENTS-1:0]                      out_keep,
    output logic                                         out_last,
    output logic [31:0]                                  unique_count,
    output logic [31:0]                                  dup_count
);

    localparam int unsigned N  = NUM_ELEMENTS;
    localparam int unsigned CW = $clog2(2 * N);

    typedef enum logic {ACCUM, FLUSH} state_e;

    state_e              state_q, state_d;
    data_t [N-1:0]       acc_q, acc_d;
    logic  [CW-1:0]      fill_q, fill_d;
    data_t [2*N-1:0]     merged;
    logic  [CW-1:0]      k, c, r, dup_k;
    logic                accept;
    logic                out_valid_d, out_last_d;
    logic  [N-1:0]       out_keep_d;
    data_t [N-1:0]       out_data_d;
    logic  [31:0]        uniq_d, dups_d;

    logic unused_origins;
    assign unused_origins = ^in_mask_origins;

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [CW-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction

    function automatic logic [N-1:0] lane_mask(logic [CW-1:0] n);
        logic [N-1:0] m;
        for (int unsigned i = 0; i < N; i++) m[i] = CW'(i) < n;
        return m;
    endfunction

    assign in_ready = rst_n && (state_q == ACCUM) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Append the kept input lanes, in lane order, after the accumulated lanes.
    always_comb begin
        merged = '0;
        k      = '0;
        dup_k  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (CW'(i) < fill_q) merged[i] = acc_q[i];
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (in_keep[i]) begin
                merged[fill_q + k] = in_data[i];
                k = k + CW'(1);
            end
            if (in_mask_duplicates[i]) dup_k = dup_k + CW'(1);
        end
        c = fill_q + k;
        r = c - CW'(N);
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        out_valid_d = out_valid && !out_ready;
        out_data_d  = out_data;
        out_keep_d  = out_keep;
        out_last_d  = out_last;
        uniq_d      = unique_count;
        dups_d      = dup_count;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    uniq_d = sat_add(unique_count, k);
                    dups_d = sat_add(dup_count, dup_k);
                    if (c >= CW'(N)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged[N-1:0];
                        out_keep_d  = '1;
                        out_last_d  = in_last && (r == '0);
                        acc_d       = merged[2*N-1:N];
                        fill_d      = r;
                        if (in_last && (r != '0)) state_d = FLUSH;
                    end else if (in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged[N-1:0];
                        out_keep_d  = lane_mask(c);
                        out_last_d  = 1'b1;
                        fill_d      = '0;
                    end else begin
                        acc_d  = merged[N-1:0];
                        fill_d = c;
                    end
                end
            end
            FLUSH: begin
                // Frame remainder goes out as its own last beat once the output slot frees.
                if (!out_valid || out_ready) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_keep_d  = lane_mask(fill_q);
                    out_last_d  = 1'b1;
                    fill_d      = '0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            fill_q       <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_keep     <= '0;
            unique_count <= '0;
            dup_count    <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            out_valid    <= out_valid_d;
            out_last     <= out_last_d;
            out_keep     <= out_keep_d;
            unique_count <= uniq_d;
            dup_count    <= dups_d;
        end
    end

    // Lane payloads are qualified by fill/keep, so they need no reset.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        out_data <= out_data_d;
    end

endmodule

// File: tb/tb_dedup_packer.sv
// Bench for dedup_packer: queue-based packing model with directed and random traffic.
module tb_dedup_packer;

    localparam int unsigned N  = 4;
    localparam int unsigned OW = N * 2;

    typedef logic [7:0] elem_t;
    typedef struct packed {
        logic [N-1:0][7:0] data;
        logic [N-1:0]      keep;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      in_mask_duplicates;
    logic [OW-1:0]     in_mask_origins;
    logic              in_valid, in_ready, in_last;
    logic [N-1:0][7:0] in_data;
    logic [N-1:0]      in_keep;
    logic              out_valid, out_ready, out_last;
    logic [N-1:0][7:0] out_data;
    logic [N-1:0]      out_keep;
    logic [31:0]       unique_count, dup_count;

    dedup_packer #(.data_t(elem_t), .NUM_ELEMENTS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_mask_duplicates(in_mask_duplicates), .in_mask_origins(in_mask_origins),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .unique_count(unique_count), .dup_count(dup_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: per-frame element queue plus expected output beats.
    elem_t  pend[$];
    beat_t  exp_q[$];
    beat_t  log_q[$];
    longint m_uniq, m_dup;
    bit     flush_owed;
    bit     hold_v;
    beat_t  hold_b;
    int     low_cnt;

    always @(negedge clk) begin : monitor
        beat_t b, e;
        bit    emitted;
        if (!rst_n) begin
            chk("ready_in_reset", in_ready, 0);
            pend.delete();
            exp_q.delete();
            m_uniq = 0; m_dup = 0; flush_owed = 0; hold_v = 0;
        end else begin
            chk("unique_count", unique_count, m_uniq);
            chk("dup_count", dup_count, m_dup);
            chk("in_ready", in_ready, !flush_owed && (!out_valid || out_ready));
            if (!in_ready) low_cnt++;
            b = '{data: out_data, keep: out_keep, last: out_last};
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_fields", b, hold_b);
            end
            if (out_valid && out_ready) begin
                log_q.push_back(b);
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_keep", out_keep, e.keep);
                    chk("out_last", out_last, e.last);
                    for (int i = 0; i < N; i++)
                        if (e.keep[i]) chk("out_data", out_data[i], e.data[i]);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_b = b;
            if (flush_owed && (!out_valid || out_ready)) flush_owed = 0;
            if (in_valid && in_ready) begin
                emitted = 0;
                for (int i = 0; i < N; i++) begin
                    if (in_keep[i]) begin pend.push_back(in_data[i]); m_uniq++; end
                    if (in_mask_duplicates[i]) m_dup++;
                end
                if (m_uniq > 64'hFFFF_FFFF) m_uniq = 64'hFFFF_FFFF;
                if (m_dup > 64'hFFFF_FFFF) m_dup = 64'hFFFF_FFFF;
                if (pend.size() >= N) begin
                    e = '0;
                    for (int i = 0; i < N; i++) e.data[i] = pend.pop_front();
                    e.keep = '1;
                    exp_q.push_back(e);
                    emitted = 1;
                end
                if (in_last) begin
                    if (pend.size() > 0) begin
                        e = '0;
                        for (int i = 0; pend.size() > 0; i++) begin
                            e.data[i] = pend.pop_front();
                            e.keep[i] = 1'b1;
                        end
                        e.last = 1'b1;
                        exp_q.push_back(e);
                        flush_owed = emitted;
                    end else if (emitted) begin
                        exp_q[exp_q.size()-1].last = 1'b1;
                    end else begin
                        e = '0;
                        e.last = 1'b1;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        in_valid = 0;
        rst_n = 0;
        repeat (cycles) tick();
        rst_n = 1;
        low_cnt = 0;
        log_q.delete();
    endtask

    task automatic send(input logic [N-1:0][7:0] d, input logic [N-1:0] k,
                        input logic [N-1:0] dp, input logic l);
        int guard = 0;
        bit took = 0;
        in_valid = 1; in_data = d; in_keep = k; in_mask_duplicates = dp; in_last = l;
        in_mask_origins = OW'($urandom());
        do begin
            @(negedge clk);
            took = in_ready;
            guard++;
            tick();
        end while (!took && guard < 200);
        if (!took) chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    initial begin
        int  sent, guard;
        bit  took;
        rst_n = 0; in_valid = 0; out_ready = 0; in_last = 0;
        in_data = '0; in_keep = '0; in_mask_duplicates = '0; in_mask_origins = '0;
        low_cnt = 0;
        tick();
        do_reset(3);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_keep", out_keep, 0);
        chk("reset_unique", unique_count, 0);

        // Split frame that needs a flush cycle.
        out_ready = 1;
        send({8'hD4, 8'h00, 8'hB2, 8'hA1}, 4'b1011, 4'b0100, 1'b0);
        send({8'h00, 8'h07, 8'hF6, 8'h00}, 4'b0110, 4'b1001, 1'b1);
        repeat (5) tick();
        chk("t1_beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t1_b0_data", log_q[0].data, 32'hF6D4B2A1);
            chk("t1_b0_keep", log_q[0].keep, 4'b1111);
            chk("t1_b0_last", log_q[0].last, 0);
            chk("t1_b1_data0", log_q[1].data[0], 8'h07);
            chk("t1_b1_keep", log_q[1].keep, 4'b0001);
            chk("t1_b1_last", log_q[1].last, 1);
        end
        chk("t1_ready_low_cycles", low_cnt, 1);

        // Two full beats, no flush.
        do_reset(2);
        out_ready = 1;
        send({8'h04, 8'h03, 8'h02, 8'h01}, 4'b1111, 4'b0000, 1'b0);
        send({8'h08, 8'h07, 8'h06, 8'h05}, 4'b1111, 4'b0000, 1'b1);
        repeat (4) tick();
        chk("t2_beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t2_b0_last", log_q[0].last, 0);
            chk("t2_b1_data", log_q[1].data, 32'h08070605);
            chk("t2_b1_last", log_q[1].last, 1);
        end
        chk("t2_unique", unique_count, 8);
        chk("t2_ready_low_cycles", low_cnt, 0);

        // All-dropped last beat.
        do_reset(2);
        send({8'h11, 8'h22, 8'h33, 8'h44}, 4'b0000, 4'b1111, 1'b1);
        repeat (4) tick();
        chk("t3_beats", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t3_keep", log_q[0].keep, 0);
            chk("t3_last", log_q[0].last, 1);
        end
        chk("t3_dup", dup_count, 4);
        chk("t3_unique", unique_count, 0);

        // Output back-pressure for 5 cycles.
        do_reset(2);
        out_ready = 0;
        send({8'h24, 8'h23, 8'h22, 8'h21}, 4'b1111, 4'b0000, 1'b0);
        in_valid = 1; in_data = {8'h28, 8'h27, 8'h26, 8'h25}; in_keep = 4'b1111; in_last = 1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_ready", in_ready, 0);
            tick();
        end
        chk("t4_no_beats", log_q.size(), 0);
        out_ready = 1;
        send({8'h28, 8'h27, 8'h26, 8'h25}, 4'b1111, 4'b0000, 1'b1);
        repeat (4) tick();
        chk("t4_beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t4_b0_data", log_q[0].data, 32'h24232221);
            chk("t4_b1_data", log_q[1].data, 32'h28272625);
            chk("t4_b1_last", log_q[1].last, 1);
        end

        // Reset while three lanes are accumulated.
        do_reset(2);
        out_ready = 1;
        send({8'h00, 8'h33, 8'h32, 8'h31}, 4'b0111, 4'b0000, 1'b0);
        repeat (3) tick();
        do_reset(2);
        repeat (3) tick();
        chk("t5_no_beats", log_q.size(), 0);
        send({8'h00, 8'h00, 8'h00, 8'h5A}, 4'b0001, 4'b0000, 1'b1);
        repeat (4) tick();
        chk("t5_beats", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t5_keep", log_q[0].keep, 4'b0001);
            chk("t5_last", log_q[0].last, 1);
            chk("t5_data0", log_q[0].data[0], 8'h5A);
        end

        // Random traffic with random back-pressure.
        do_reset(2);
        sent = 0; guard = 0; took = 0;
        while (sent < 10000 && guard < 90000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || took) begin
                if ($urandom_range(0, 4) != 0) begin
                    in_valid = 1;
                    in_data = $urandom();
                    in_keep = N'($urandom());
                    in_mask_duplicates = N'($urandom());
                    in_mask_origins = OW'($urandom());
                    in_last = ($urandom_range(0, 3) == 0);
                end else begin
                    in_valid = 0;
                end
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) sent++;
            tick();
            guard++;
        end
        in_valid = 0;
        if (sent < 10000) chk("random_timeout", sent, 10000);
        out_ready = 1;
        send('0, 4'b0000, 4'b0000, 1'b1);
        repeat (10) tick();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_pend", pend.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dedup_packer.md
DEDUP_PACKER -- requirements
Module: dedup_packer

Interface
REQ-001 SHALL have parameter data_t, no default, type of one lane element.
REQ-002 SHALL have parameter NUM_ELEMENTS, no default, lanes per beat (N), N >= 2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_mask  duplicate_i slave  #(N)  per-lane duplicates bit and origins, qualified by in.valid and in.ready.
REQ-006 SHALL have port in  ndata_i slave  #(data_t, N)  deduplicated beat; keep=0 marks dropped or empty lanes.
REQ-007 SHALL have port out  ndata_i master  #(data_t, N)  packed beats of unique elements.
REQ-008 SHALL have port unique_count  output  32  saturating count of accepted kept lanes.
REQ-009 SHALL have port dup_count  output  32  saturating count of accepted lanes with duplicates=1.

Function
REQ-010 SHALL accept an input beat only when in.valid && in.ready; in_mask is sampled on the same cycle.
REQ-011 SHALL drive in.ready = (state == ACCUM) && (!out.valid || out.ready), combinationally.
REQ-012 SHALL hold an accumulator of N lanes plus fill count F (0..N-1) and a single registered output beat.
REQ-013 SHALL compact the kept lanes of an accepted beat (k = popcount(keep)) in ascending lane order and append them after the F accumulated lanes; combined C = F + k.
REQ-014 SHALL, when C >= N, load the output with the first N combined lanes, keep all ones, valid=1; remainder R = C - N becomes the new accumulator, F = R.
REQ-015 SHALL, when C >= N and in.last: set out.last = (R == 0); if R > 0, enter state FLUSH.
REQ-016 SHALL, when C < N and in.last, load the output with C lanes at lanes 0..C-1, keep = lanes < C, last=1, and clear F to 0; C=0 produces a keep-all-zero beat with last=1.
REQ-017 SHALL, when C < N and !in.last, store the C lanes in the accumulator, set F = C, and produce no output beat.
REQ-018 SHALL, in FLUSH, when !out.valid || out.ready, emit the accumulator (keep = lanes < F, last=1), clear F to 0, and return to ACCUM.
REQ-019 SHALL hold out.data, out.keep, and out.last stable while out.valid && !out.ready.
REQ-020 SHALL clear out.valid when out.ready is high and no new beat is loaded that cycle.
REQ-021 SHALL load an output beat one cycle after the accepting or flushing edge; there is no combinational in-to-out path.
REQ-022 SHALL drive out.keep lanes at or above the valid count to 0 and their data to don't-care.
REQ-023 SHALL add k to unique_count and popcount(in_mask.duplicates) to dup_count per accepted beat, saturating at 2^32-1.
REQ-024 SHALL ignore in_mask.origins.
REQ-025 SHALL never drop, duplicate, or reorder kept elements.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set state=ACCUM, F=0, out.valid=0, out.last=0, out.keep=0, and both counters to 0.
REQ-027 SHALL discard the accumulator and any pending output beat on reset mid-stream, without emitting them.
REQ-028 SHALL hold in.ready=0 during reset.

Verification (N=4)
REQ-029 SHALL cover: beats keep=1011 (A,B,_,D) then 0110 (_,F,G,_) last, out.ready=1 -> out A,B,D,F keep=1111 last=0, then G keep=0001 last=1 via FLUSH; in.ready low for exactly 1 cycle.
REQ-030 SHALL cover: keep=1111, keep=1111 last -> two full beats, second with last=1 and no FLUSH; unique_count=8.
REQ-031 SHALL cover: a single beat keep=0000, duplicates=1111, last -> one out beat keep=0000 last=1; dup_count=4, unique_count=0.
REQ-032 SHALL cover: out.ready=0 for 5 cycles with an output pending -> in.ready=0, out fields stable; data resumes on release with no loss.
REQ-033 SHALL cover: rst_n pulsed with F=3 -> no output emitted; next frame keep=0001 last -> single beat, 1 lane, last=1.
REQ-034 SHALL cover: random keep, valid, and ready over 10k beats -> output stream equals the in-order concatenation of kept lanes per frame, and frame boundaries are preserved.
